uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter directly downstream of the APB-to-UART interface.
- Accepts one byte per start request on txStart/txData and serialises it LSB-first on line tx: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Reports completion with a txDone pulse and reports activity on busy. The interface uses these to step through its 4-byte FIFO.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity and 0 selects even parity; ignored when PARITY_EN is 0.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  transmitter enable from the APB interface.
- txStart  input  1  start request; level-held by the upstream block.
- txData  input  8  byte to send; sampled on accept.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- txDone  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, txDone=0.
  - State=IDLE, bit counter=0, baud counter=0, shift register=0, txStart edge register=0.
- Start detection:
  - txStart is registered every cycle.
  - start_rise = txStart & ~txStart_q.
  - Upstream holds txStart high until txDone, so level triggering is forbidden.
- Accept:
  - Condition: in IDLE, tx_en=1 and start_rise=1.
  - On that edge: latch txData into the shift register, compute the parity bit from the latched byte, set busy=1, enter START.
  - tx=0 from the first cycle after the accept edge.
- start_rise outside IDLE, or with tx_en=0, is ignored. It is not queued.
- Baud timing:
  - The counter runs 0..CLKS_PER_BIT-1.
  - bit_tick fires when the count equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - The counter is held at 0 in IDLE.
  - Each bit is driven for exactly CLKS_PER_BIT cycles.
- State machine (all outputs registered):
  - IDLE: tx=1, busy=0.
  - START: tx=0. On bit_tick go to DATA with bit index 0.
  - DATA: tx=shift[0]. On bit_tick shift right and increment the index. After index 7's tick go to PARITY if PARITY_EN=1, otherwise STOP.
  - PARITY: tx = ^data ^ PARITY_ODD. On bit_tick go to STOP.
  - STOP: tx=1. On the tick of the last stop bit go to IDLE; a stop-bit counter handles STOP_BITS=2.
- Frame end, on the edge leaving STOP: txDone=1 for exactly one cycle, busy=0, tx=1.
- Frame length from accept edge to txDone edge: CLKS_PER_BIT*(9+PARITY_EN+STOP_BITS) cycles.
- Back-to-back frames:
  - The earliest next accept is the cycle after txDone, once upstream has dropped txStart and raised it again.
  - The minimum gap is therefore one extra stop-level idle of at least 2 cycles.
- Abort: tx_en=0 in any non-IDLE state.
  - Next edge: go to IDLE, tx=1, busy=0.
  - No txDone is issued and the byte is discarded.
- txData changes after accept have no effect on the frame.
- Reset mid-frame: line returns high immediately; no txDone.

Decomposition:
- uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - DATA_BITS=8.
  - Frame-length helper constant.
  - Shared with the future uart_rx.
- Sub-module uart_baud_gen:
  - Inputs: clk, rst_n, run.
  - Output: bit_tick.
  - Parameter: CLKS_PER_BIT.
  - Reused by the receiver, which runs it at half-bit offset.

Test Plan:
- Basic frame, CLKS_PER_BIT=4, defaults, txData=8'hA5, tx_en=1, txStart raised:
  - tx sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - busy=1 for 40 cycles.
  - txDone pulses once, 40 cycles after the accept edge.
- Parity and two stop bits, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, txData=8'h07:
  - Parity slot=1.
  - 12 slots total; txDone 48 cycles after accept.
  - Repeat with PARITY_ODD=1: parity slot=0.
- Level hold:
  - Keep txStart high across txDone and for 100 further cycles.
  - Required: exactly one frame, no retrigger.
  - Drop txStart and raise it again: a second frame starts on the following cycle.
- Four-byte burst emulating upstream, bytes 8'h11, 8'h22, 8'h33, 8'h44, each request raised after the previous txDone:
  - Four frames decode in order.
  - Exactly four txDone pulses.
- Abort and ignore:
  - Drop tx_en during data bit 3: tx=1 and busy=0 on the next cycle, no txDone.
  - start_rise during busy with a different txData: current frame unchanged, no second frame.
- Async reset at mid-frame (cycle 17):
  - tx=1, busy=0 without waiting for a clock edge.
  - After rst_n is released, a normal frame of 8'h3C completes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : frame-level types and constants shared by the UART TX/RX blocks
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clock cycles from frame accept to frame completion.
  function automatic int frame_clks(input int clks_per_bit, input int parity_en,
                                    input int stop_bits);
    return clks_per_bit * (1 + DATA_BITS + parity_en + stop_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen : bit-period counter, ticks once every CLKS_PER_BIT cycles
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = run && (cnt_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx  : edge-triggered UART transmitter, LSB first, optional parity
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       tx,
  output logic       busy,
  output logic       txDone
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 parity_q, parity_d;
  logic                 start_q;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_rise;
  logic                 bit_tick;
  logic                 run;

  assign start_rise = txStart & ~start_q;
  // Dropping tx_en also clears the baud counter on the abort edge.
  assign run        = (state_q != IDLE) && tx_en;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (tx_en && start_rise) begin
        shift_d    = txData;
        parity_d   = (^txData) ^ ODD;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
    end else if (!tx_en) begin
      state_d = IDLE;
    end else if (bit_tick) begin
      case (state_q)
        START: begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
        PARITY: begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Line level follows the state being entered so every output is a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      start_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      start_q    <= txStart;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx     = tx_q;
  assign busy   = busy_q;
  assign txDone = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed bench for uart_tx in three framing configurations
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

  localparam int C = 4;
  localparam int PE_V [3] = '{0, 1, 1};
  localparam int PO_V [3] = '{0, 0, 1};
  localparam int SB_V [3] = '{1, 2, 2};
  localparam int NONE = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [7:0] txData = 8'h00;
  logic [2:0] tx_v, busy_v, done_v;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic exp_q [$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .txStart(start_v[0]), .txData(txData),
    .tx(tx_v[0]), .busy(busy_v[0]), .txDone(done_v[0]));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .txStart(start_v[1]), .txData(txData),
    .tx(tx_v[1]), .busy(busy_v[1]), .txDone(done_v[1]));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .txStart(start_v[2]), .txData(txData),
    .tx(tx_v[2]), .busy(busy_v[2]), .txDone(done_v[2]));

  // Pulse monitor, sampled well clear of both clock edges.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) done_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_wait(input int sel, input int n, output int busy_cnt);
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy_v[sel] === 1'b1) busy_cnt++;
    end
  endtask

  // Expected line levels are queued per slot, then popped at each slot midpoint.
  task automatic frame(input int sel, input logic [7:0] b, input bit drop, input int glitch);
    int   n;
    int   busy_cnt;
    logic e;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (PE_V[sel] != 0) exp_q.push_back((^b) ^ PO_V[sel][0]);
    for (int s = 0; s < SB_V[sel]; s++) exp_q.push_back(1'b1);
    n = exp_q.size() * C;
    @(negedge clk);
    txData       = b;
    start_v[sel] = 1'b1;
    @(negedge clk);
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (busy_v[sel] === 1'b1) busy_cnt++;
      if (k % C == C / 2) begin
        e = exp_q.pop_front();
        chk($sformatf("slot%0d_dut%0d", k / C, sel), 32'(tx_v[sel]), 32'(e));
      end
      if (k == glitch) start_v[sel] = 1'b0;
      if (k == glitch + 1) begin
        start_v[sel] = 1'b1;
        txData       = ~b;
      end
      @(negedge clk);
    end
    chk("done_at_end", 32'(done_v[sel]), 32'd1);
    chk("busy_at_end", 32'(busy_v[sel]), 32'd0);
    chk("tx_at_end",   32'(tx_v[sel]),   32'd1);
    chk("busy_len",    32'(busy_cnt),    32'(n));
    if (drop) start_v[sel] = 1'b0;
  endtask

  initial begin
    int snap;
    int bc;

    // Reset state
    #12;
    chk("rst_tx",   32'(tx_v[0]),   32'd1);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, then parity/two-stop frames in even and odd parity
    frame(0, 8'hA5, 1'b1, NONE);
    frame(1, 8'h07, 1'b1, NONE);
    frame(2, 8'h07, 1'b1, NONE);
    idle_wait(0, 3, bc);
    chk("done_cnt0_basic", 32'(done_cnt[0]), 32'd1);
    chk("done_cnt1", 32'(done_cnt[1]), 32'd1);
    chk("done_cnt2", 32'(done_cnt[2]), 32'd1);

    // Level hold: no retrigger while txStart stays high
    snap = done_cnt[0];
    frame(0, 8'h5A, 1'b0, NONE);
    idle_wait(0, 100, bc);
    chk("hold_busy_cycles", 32'(bc), 32'd0);
    chk("hold_done_count", 32'(done_cnt[0] - snap), 32'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    frame(0, 8'hC6, 1'b1, NONE);

    // Four-byte burst, each request right after the previous txDone
    idle_wait(0, 2, bc);
    snap = done_cnt[0];
    frame(0, 8'h11, 1'b1, NONE);
    frame(0, 8'h22, 1'b1, NONE);
    frame(0, 8'h33, 1'b1, NONE);
    frame(0, 8'h44, 1'b1, NONE);
    idle_wait(0, 3, bc);
    chk("burst_done_count", 32'(done_cnt[0] - snap), 32'd4);

    // Abort during data bit 3
    snap = done_cnt[0];
    @(negedge clk);
    txData     = 8'h00;
    start_v[0] = 1'b1;
    @(negedge clk);
    repeat (4 * C + 1) @(negedge clk);
    chk("pre_abort_tx",   32'(tx_v[0]),   32'd0);
    chk("pre_abort_busy", 32'(busy_v[0]), 32'd1);
    tx_en = 1'b0;
    @(negedge clk);
    chk("abort_tx",   32'(tx_v[0]),   32'd1);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    tx_en      = 1'b1;
    start_v[0] = 1'b0;
    idle_wait(0, 60, bc);
    chk("abort_busy_after", 32'(bc), 32'd0);
    chk("abort_no_done", 32'(done_cnt[0] - snap), 32'd0);

    // start_rise while busy with different data is ignored
    snap = done_cnt[0];
    frame(0, 8'h96, 1'b1, 8);
    idle_wait(0, 60, bc);
    chk("ignore_busy_after", 32'(bc), 32'd0);
    chk("ignore_done_count", 32'(done_cnt[0] - snap), 32'd1);

    // Asynchronous reset mid-frame at cycle 17
    snap = done_cnt[0];
    @(negedge clk);
    txData     = 8'h00;
    start_v[0] = 1'b1;
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", 32'(tx_v[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx",   32'(tx_v[0]),   32'd1);
    chk("async_rst_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    start_v[0] = 1'b0;
    idle_wait(0, 3, bc);
    chk("rst_no_done", 32'(done_cnt[0] - snap), 32'd0);
    frame(0, 8'h3C, 1'b1, NONE);
    idle_wait(0, 3, bc);
    chk("post_rst_done", 32'(done_cnt[0] - snap), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
